// File: rtl/mem_model_burst_arb_if.sv
// Bus bundle for mem_model_burst_arb: command-queue side and memory-port side.
// The scheduler connects through the slave modport; the environment
// (queues + memory model) drives the master side.
interface mem_model_burst_arb_if #(
    parameter int NUMREQ = 4,
    parameter int ADDRW  = 32,
    parameter int LENW   = 12
);
    localparam int CMDW = ADDRW + LENW + 1;
    localparam int GW   = $clog2(NUMREQ);

    logic                     clr;
    logic [NUMREQ-1:0]        q_empty;
    logic [NUMREQ*CMDW-1:0]   q_rdata;
    logic [NUMREQ-1:0]        q_read;
    logic [ADDRW-1:0]         mem_addr;
    logic                     mem_rd;
    logic                     mem_wr;
    logic                     mem_wait;
    logic [GW-1:0]            grant;
    logic                     busy;
    logic                     burst_done;

    modport slave (
        input  clr, q_empty, q_rdata, mem_wait,
        output q_read, mem_addr, mem_rd, mem_wr, grant, busy, burst_done
    );

    modport master (
        output clr, q_empty, q_rdata, mem_wait,
        input  q_read, mem_addr, mem_rd, mem_wr, grant, busy, burst_done
    );
endinterface

// File: rtl/mem_model_burst_arb.sv
// Round-robin burst scheduler: pops one command from a non-empty queue and
// expands it into len word accesses on the memory port, honouring mem_wait.
// Optional build macro MEM_MODEL_ARB_FIXED_PRIO_EN selects fixed priority
// (lowest-index non-empty queue wins) instead of round-robin.
module mem_model_burst_arb #(
    parameter int NUMREQ = 4,
    parameter int ADDRW  = 32,
    parameter int LENW   = 12
) (
    input  logic                     clk,
    input  logic                     reset_n,
    mem_model_burst_arb_if.slave     bus
);
    localparam int CMDW = ADDRW + LENW + 1;
    localparam int GW   = $clog2(NUMREQ);

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } state_t;

    state_t             state_q, state_d;
    logic               wr_q, wr_d;
    logic [ADDRW-1:0]   base_q, base_d;
    logic [LENW-1:0]    len_q, len_d;
    logic [LENW-1:0]    beat_q, beat_d;
    logic [GW-1:0]      grant_q, grant_d;
    logic               done_q, done_d;
`ifndef MEM_MODEL_ARB_FIXED_PRIO_EN
    logic [GW-1:0]      last_q, last_d;
`endif

    logic [GW-1:0]      win_g;
    logic               found;
    logic               pop;
    logic [CMDW-1:0]    head;
    logic [NUMREQ-1:0]  q_read_c;

    // Winner selection among non-empty queues
    always_comb begin
        win_g = '0;
        found = 1'b0;
`ifdef MEM_MODEL_ARB_FIXED_PRIO_EN
        for (int unsigned i = 0; i < NUMREQ; i++) begin
            if (!found && !bus.q_empty[GW'(i)]) begin
                found = 1'b1;
                win_g = GW'(i);
            end
        end
`else
        for (int unsigned off = 1; off <= NUMREQ; off++) begin
            int unsigned cand;
            cand = (32'(last_q) + off) % NUMREQ;
            if (!found && !bus.q_empty[GW'(cand)]) begin
                found = 1'b1;
                win_g = GW'(cand);
            end
        end
`endif
    end

    assign pop  = (state_q == ST_IDLE) && !bus.clr && found;
    assign head = bus.q_rdata[win_g*CMDW +: CMDW];

    // One-hot pop strobe, only in IDLE and only towards the selected queue
    always_comb begin
        q_read_c = '0;
        if (pop) begin
            q_read_c[win_g] = 1'b1;
        end
    end

    // Next-state and burst bookkeeping
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        base_d  = base_q;
        len_d   = len_q;
        beat_d  = beat_q;
        grant_d = grant_q;
        done_d  = 1'b0;
`ifndef MEM_MODEL_ARB_FIXED_PRIO_EN
        last_d  = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    wr_d    = head[CMDW-1];
                    base_d  = head[ADDRW+LENW-1:LENW];
                    len_d   = head[LENW-1:0];
                    grant_d = win_g;
`ifndef MEM_MODEL_ARB_FIXED_PRIO_EN
                    last_d  = win_g;
`endif
                    // A zero-length command completes without touching memory
                    if (head[LENW-1:0] != '0) begin
                        state_d = ST_BURST;
                        beat_d  = '0;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            ST_BURST: begin
                if (bus.clr) begin
                    state_d = ST_IDLE;
                end else if (!bus.mem_wait) begin
                    if (beat_q == len_q - LENW'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        beat_d  = beat_q + LENW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and command registers, asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            wr_q    <= 1'b0;
            base_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            grant_q <= '0;
            done_q  <= 1'b0;
`ifndef MEM_MODEL_ARB_FIXED_PRIO_EN
            last_q  <= GW'(NUMREQ - 1);
`endif
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            base_q  <= base_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            grant_q <= grant_d;
            done_q  <= done_d;
`ifndef MEM_MODEL_ARB_FIXED_PRIO_EN
            last_q  <= last_d;
`endif
        end
    end

    assign bus.q_read     = q_read_c;
    assign bus.mem_addr   = (state_q == ST_BURST) ? (base_q + ADDRW'(beat_q)) : '0;
    assign bus.mem_rd     = (state_q == ST_BURST) && !wr_q;
    assign bus.mem_wr     = (state_q == ST_BURST) && wr_q;
    assign bus.grant      = grant_q;
    assign bus.busy       = (state_q == ST_BURST);
    assign bus.burst_done = done_q;
endmodule

// File: tb/tb_mem_model_burst_arb.sv
// Self-checking bench for mem_model_burst_arb: directed timing checks plus
// randomized queue contents compared with a burst-level reference model.
module tb_mem_model_burst_arb;
    localparam int NUMREQ = 4;
    localparam int ADDRW  = 32;
    localparam int LENW   = 12;
    localparam int CMDW   = ADDRW + LENW + 1;

    typedef logic [CMDW-1:0] cmd_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    mem_model_burst_arb_if #(.NUMREQ(NUMREQ), .ADDRW(ADDRW), .LENW(LENW)) bus ();

    mem_model_burst_arb #(.NUMREQ(NUMREQ), .ADDRW(ADDRW), .LENW(LENW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int tests = 0;
    int fails = 0;

    cmd_t fifo [NUMREQ][$];

    logic [NUMREQ-1:0] s_qread, s_empty;
    logic              s_rd, s_wr, s_done, s_busy, s_wait;
    logic [ADDRW-1:0]  s_addr;
    logic [1:0]        s_grant;

    int          obs_pop[$];
    logic [1:0]  obs_grant[$];
    logic [32:0] obs_beat[$];
    int          done_cnt;
    int          strobe_cycles;
    bit          pend_grant;
    bit          rand_wait;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic cmd_t mk(input logic wr, input logic [31:0] a, input logic [11:0] l);
        return {wr, a, l};
    endfunction

    function automatic bit all_empty();
        for (int i = 0; i < NUMREQ; i++) if (fifo[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < NUMREQ; i++) begin
            bus.q_empty[i] = (fifo[i].size() == 0);
            bus.q_rdata[i*CMDW +: CMDW] = (fifo[i].size() != 0) ? fifo[i][0] : '0;
        end
    endtask

    task automatic clear_obs();
        obs_pop.delete();
        obs_grant.delete();
        obs_beat.delete();
        done_cnt = 0;
        strobe_cycles = 0;
        pend_grant = 1'b0;
    endtask

    // One clock cycle: sample outputs mid-cycle, then apply pops and new inputs.
    task automatic tick();
        @(negedge clk);
        s_qread = bus.q_read;
        s_empty = bus.q_empty;
        s_rd    = bus.mem_rd;
        s_wr    = bus.mem_wr;
        s_addr  = bus.mem_addr;
        s_done  = bus.burst_done;
        s_busy  = bus.busy;
        s_grant = bus.grant;
        s_wait  = bus.mem_wait;
        if (pend_grant) begin
            obs_grant.push_back(s_grant);
            pend_grant = 1'b0;
        end
        check("pop_to_empty", 64'(s_qread & s_empty), 64'd0);
        check("pop_onehot", 64'($countones(s_qread) <= 1), 64'd1);
        if (s_qread != '0) begin
            for (int i = 0; i < NUMREQ; i++) if (s_qread[i]) obs_pop.push_back(i);
            pend_grant = 1'b1;
        end
        if (s_rd | s_wr) strobe_cycles++;
        if ((s_rd | s_wr) && !s_wait) obs_beat.push_back({s_wr, s_addr});
        if (s_done) done_cnt++;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUMREQ; i++)
            if (s_qread[i] && fifo[i].size() != 0) void'(fifo[i].pop_front());
        if (rand_wait) bus.mem_wait = ($urandom_range(0, 9) < 3);
        drive_inputs();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.clr = 1'b0;
        bus.mem_wait = 1'b0;
        for (int i = 0; i < NUMREQ; i++) fifo[i].delete();
        drive_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        clear_obs();
    endtask

    // Drain the loaded queues and compare against a burst-level model that
    // starts from the reset arbitration pointer.
    task automatic run_and_compare(input string tag);
        cmd_t        m [NUMREQ][$];
        int          exp_pop[$];
        logic [32:0] exp_beat[$];
        int          ncmd = 0;
        int          last = NUMREQ - 1;
        bit          finished = 1'b0;
        for (int i = 0; i < NUMREQ; i++) begin
            m[i] = fifo[i];
            ncmd += m[i].size();
        end
        clear_obs();
        for (int c = 0; c < 4000 && !finished; c++) begin
            tick();
            finished = all_empty() && (done_cnt == ncmd) && !s_busy;
        end
        check({tag, "_finished"}, 64'(finished), 64'd1);

        forever begin
            int   g = -1;
            cmd_t cmd;
`ifdef MEM_MODEL_ARB_FIXED_PRIO_EN
            for (int i = NUMREQ - 1; i >= 0; i--) if (m[i].size() != 0) g = i;
`else
            for (int off = NUMREQ; off >= 1; off--)
                if (m[(last + off) % NUMREQ].size() != 0) g = (last + off) % NUMREQ;
`endif
            if (g < 0) break;
            cmd = m[g].pop_front();
            exp_pop.push_back(g);
            for (int k = 0; k < int'(cmd[11:0]); k++) begin
                logic [31:0] a;
                a = cmd[43:12] + 32'(k);
                exp_beat.push_back({cmd[44], a});
            end
            last = g;
        end

        check({tag, "_npop"}, 64'(obs_pop.size()), 64'(exp_pop.size()));
        check({tag, "_ngrant"}, 64'(obs_grant.size()), 64'(exp_pop.size()));
        check({tag, "_nbeat"}, 64'(obs_beat.size()), 64'(exp_beat.size()));
        check({tag, "_ndone"}, 64'(done_cnt), 64'(ncmd));
        for (int k = 0; k < exp_pop.size(); k++) begin
            if (k < obs_pop.size())   check({tag, "_pop"}, 64'(obs_pop[k]), 64'(exp_pop[k]));
            if (k < obs_grant.size()) check({tag, "_grant"}, 64'(obs_grant[k]), 64'(exp_pop[k]));
        end
        for (int k = 0; k < exp_beat.size(); k++)
            if (k < obs_beat.size()) check({tag, "_beat"}, 64'(obs_beat[k]), 64'(exp_beat[k]));
    endtask

    initial begin
        int          first_q;
        int          exp_rr[5];
        logic        wpat[5];
        logic [31:0] apat[5];

        rand_wait = 1'b0;
        reset_n = 1'b0;
        bus.clr = 1'b0;
        bus.mem_wait = 1'b0;
        clear_obs();
        drive_inputs();
        #1;
        check("rst_q_read", 64'(bus.q_read), 64'd0);
        check("rst_addr", 64'(bus.mem_addr), 64'd0);
        check("rst_rd", 64'(bus.mem_rd), 64'd0);
        check("rst_wr", 64'(bus.mem_wr), 64'd0);
        check("rst_grant", 64'(bus.grant), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.burst_done), 64'd0);
        do_reset();

        // Plain 3-beat read burst
        fifo[0].push_back(mk(1'b0, 32'h100, 12'd3));
        drive_inputs();
        tick();
        check("b3_q_read", 64'(s_qread), 64'd1);
        check("b3_rd_pop_cycle", 64'(s_rd), 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("b3_rd", 64'(s_rd), 64'd1);
            check("b3_wr", 64'(s_wr), 64'd0);
            check("b3_addr", 64'(s_addr), 64'(32'h100 + k));
            check("b3_busy", 64'(s_busy), 64'd1);
            check("b3_done_early", 64'(s_done), 64'd0);
        end
        tick();
        check("b3_rd_after", 64'(s_rd), 64'd0);
        check("b3_done", 64'(s_done), 64'd1);
        check("b3_busy_after", 64'(s_busy), 64'd0);
        check("b3_grant", 64'(s_grant), 64'd0);
        tick();
        check("b3_done_pulse", 64'(s_done), 64'd0);

        // Same burst with two stall cycles on beat 1
        fifo[0].push_back(mk(1'b0, 32'h100, 12'd3));
        drive_inputs();
        clear_obs();
        tick();
        check("st_q_read", 64'(s_qread), 64'd1);
        wpat = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        apat = '{32'h100, 32'h101, 32'h101, 32'h101, 32'h102};
        for (int k = 0; k < 5; k++) begin
            bus.mem_wait = wpat[k];
            tick();
            check("st_rd", 64'(s_rd), 64'd1);
            check("st_addr", 64'(s_addr), 64'(apat[k]));
        end
        bus.mem_wait = 1'b0;
        tick();
        check("st_rd_after", 64'(s_rd), 64'd0);
        check("st_done", 64'(s_done), 64'd1);
        tick();
        check("st_strobe_cycles", 64'(strobe_cycles), 64'd5);
        check("st_done_count", 64'(done_cnt), 64'd1);

        // Arbitration order with every queue holding len=1 writes
        do_reset();
        for (int i = 0; i < NUMREQ; i++) fifo[i].push_back(mk(1'b1, 32'h200 + 32'(i * 16), 12'd1));
        fifo[0].push_back(mk(1'b1, 32'h300, 12'd1));
        drive_inputs();
        run_and_compare("order");
`ifdef MEM_MODEL_ARB_FIXED_PRIO_EN
        exp_rr = '{0, 0, 1, 2, 3};
`else
        exp_rr = '{0, 1, 2, 3, 0};
`endif
        for (int k = 0; k < 5; k++)
            if (k < obs_grant.size()) check("order_grant_seq", 64'(obs_grant[k]), 64'(exp_rr[k]));

        // Address wrap at the top of the address space
        do_reset();
        fifo[1].push_back(mk(1'b0, 32'hFFFF_FFFF, 12'd2));
        drive_inputs();
        run_and_compare("wrap");
        if (obs_beat.size() == 2) begin
            check("wrap_beat0", 64'(obs_beat[0]), 64'({1'b0, 32'hFFFF_FFFF}));
            check("wrap_beat1", 64'(obs_beat[1]), 64'({1'b0, 32'h0000_0000}));
        end

        // Zero-length command
        do_reset();
        fifo[2].push_back(mk(1'b0, 32'h40, 12'd0));
        drive_inputs();
        tick();
        check("len0_q_read", 64'(s_qread), 64'b0100);
        check("len0_rd0", 64'(s_rd | s_wr), 64'd0);
        tick();
        check("len0_done", 64'(s_done), 64'd1);
        check("len0_strobe", 64'(s_rd | s_wr), 64'd0);
        check("len0_busy", 64'(s_busy), 64'd0);
        check("len0_grant", 64'(s_grant), 64'd2);
        tick();
        check("len0_done_pulse", 64'(s_done), 64'd0);

        // Abort on beat 2 of a len=8 burst, then resume arbitration
        do_reset();
        fifo[0].push_back(mk(1'b0, 32'h500, 12'd8));
        drive_inputs();
        tick();
        tick();
        tick();
        bus.clr = 1'b1;
        tick();
        check("clr_beat2_addr", 64'(s_addr), 64'h502);
        check("clr_beat2_rd", 64'(s_rd), 64'd1);
        bus.clr = 1'b0;
        fifo[0].push_back(mk(1'b0, 32'h600, 12'd1));
        fifo[1].push_back(mk(1'b0, 32'h700, 12'd1));
        drive_inputs();
        clear_obs();
        tick();
        check("clr_rd_after", 64'(s_rd), 64'd0);
        check("clr_no_done", 64'(s_done), 64'd0);
        check("clr_busy", 64'(s_busy), 64'd0);
`ifdef MEM_MODEL_ARB_FIXED_PRIO_EN
        first_q = 0;
`else
        first_q = 1;
`endif
        check("clr_next_pop", 64'(s_qread), 64'(1 << first_q));
        tick();
        check("clr_next_addr", 64'(s_addr), 64'(first_q == 0 ? 32'h600 : 32'h700));
        bus.clr = 1'b1;
        tick();
        check("clr_idle_block", 64'(s_qread), 64'd0);
        check("clr_idle_done", 64'(s_done), 64'd1);
        bus.clr = 1'b0;
        tick();
        check("clr_idle_resume", 64'(s_qread), 64'(1 << (1 - first_q)));
        tick();
        tick();

        // Asynchronous reset in the middle of a burst
        do_reset();
        fifo[2].push_back(mk(1'b1, 32'h800, 12'd6));
        drive_inputs();
        tick();
        tick();
        tick();
        check("arst_pre_busy", 64'(s_busy), 64'd1);
        reset_n = 1'b0;
        #1;
        check("arst_q_read", 64'(bus.q_read), 64'd0);
        check("arst_addr", 64'(bus.mem_addr), 64'd0);
        check("arst_rd", 64'(bus.mem_rd), 64'd0);
        check("arst_wr", 64'(bus.mem_wr), 64'd0);
        check("arst_grant", 64'(bus.grant), 64'd0);
        check("arst_busy", 64'(bus.busy), 64'd0);
        check("arst_done", 64'(bus.burst_done), 64'd0);

        // Randomized queue contents with random stalls
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int i = 0; i < NUMREQ; i++) begin
                int n = $urandom_range(0, 4);
                for (int j = 0; j < n; j++) begin
                    logic [31:0] a;
                    a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                                    : 32'($urandom);
                    fifo[i].push_back(mk(1'($urandom_range(0, 1)), a, 12'($urandom_range(0, 6))));
                end
            end
            drive_inputs();
            rand_wait = 1'b1;
            run_and_compare("rand");
            rand_wait = 1'b0;
            bus.mem_wait = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
